muldiv_ctrl: RTL

Sequencer and owner of the HI/LO register pair for the pipelined MIPS core. Accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MUL/MTHI/MTLO operations from the EX stage and runs multiplies on an iterative shift-add datapath. Serves MFHI/MFLO/MUL reads from the MEM stage, which uses the writeback select code 3'b011. Raises a stall toward the pipeline hazard logic while a multiply is in flight.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_ctrl_if.sv | 26 ++
 rtl/mul_iter_core.sv | 58 +++++
 rtl/muldiv_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply sequencer: op codes, FSM states,
// read-select codes and op classification helpers.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_MTHI  = 4'd0,
    OP_MTLO  = 4'd1,
    OP_MULT  = 4'd2,
    OP_MULTU = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_MUL   = 4'd8
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIN
  } state_e;

  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_HI   = 2'b01;
  localparam logic [1:0] RD_LO   = 2'b10;
  localparam logic [1:0] RD_MUL  = 2'b11;

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_MUL);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Pipeline-facing bundle of the HI/LO unit: EX-stage op issue, MEM-stage
// reads and the status lines toward hazard logic.
interface muldiv_ctrl_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic [1:0]  rd_sel;
  logic [31:0] rd_data;
  logic        ready;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, flush, rd_sel,
    input  rd_data, ready, busy, stall, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush, rd_sel,
    output rd_data, ready, busy, stall, hi, lo
  );
endinterface

// File: rtl/mul_iter_core.sv
// Unsigned 32x32 shift-add multiplier retiring RADIX_BITS multiplier bits
// per step into a 64-bit accumulator; done flags the final step.
module mul_iter_core #(
  parameter int RADIX_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [63:0] acc,
  output logic        done
);

  localparam int N  = 32 / RADIX_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt;
  logic [63:0]   mcand;
  logic [31:0]   mplier;

  function automatic logic [63:0] partial(input logic [63:0] m,
                                          input logic [RADIX_BITS-1:0] d);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (d[i]) s = s + (m << i);
    end
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(N - 1);
    end else if (step && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Datapath carries no reset: it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (load) begin
      mcand  <= {32'h0, a_mag};
      mplier <= b_mag;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc + partial(mcand, mplier[RADIX_BITS-1:0]);
      mcand  <= mcand << RADIX_BITS;
      mplier <= mplier >> RADIX_BITS;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and multiply sequencer: IDLE/CALC/FIN control, sign fix-up of
// the magnitude product, accumulate/subtract into {HI,LO} and MUL result.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int          RADIX_BITS = 2,
  parameter logic [31:0] RESET_HILO = 32'h0
) (
  input logic         clk,
  input logic         rst,
  muldiv_ctrl_if.slave bus
);

  state_e             state;
  logic [31:0]        hi_r, lo_r, mul_res;
  logic               neg;
  logic [3:0]         op_q;
  logic               idle, accept, load_mul, step, calc_done;
  logic [31:0]        a_mag, b_mag;
  logic [63:0]        acc, hilo;
  logic signed [31:0] rs_s, rt_s;
  logic signed [63:0] prod;

  function automatic logic [31:0] mag(input logic signed [31:0] v, input logic sgn);
    return (sgn && (v < 0)) ? 32'(-v) : 32'(v);
  endfunction

  assign rs_s     = bus.rs_val;
  assign rt_s     = bus.rt_val;
  assign idle     = (state == ST_IDLE);
  assign accept   = bus.start && idle && !bus.flush;
  assign load_mul = accept && is_mul(bus.op);
  assign step     = (state == ST_CALC) && !bus.flush;
  assign a_mag    = mag(rs_s, is_signed(bus.op));
  assign b_mag    = mag(rt_s, is_signed(bus.op));

  mul_iter_core #(.RADIX_BITS(RADIX_BITS)) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (load_mul),
    .step  (step),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .acc   (acc),
    .done  (calc_done)
  );

  assign prod = neg ? -$signed(acc) : $signed(acc);
  assign hilo = {hi_r, lo_r};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      hi_r    <= RESET_HILO;
      lo_r    <= RESET_HILO;
      mul_res <= '0;
      neg     <= 1'b0;
      op_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (bus.op)
              OP_MTHI: hi_r <= bus.rs_val;
              OP_MTLO: lo_r <= bus.rs_val;
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
              OP_MSUB, OP_MSUBU, OP_MUL: begin
                state <= ST_CALC;
                neg   <= is_signed(bus.op) && (rs_s[31] ^ rt_s[31]);
                op_q  <= bus.op;
              end
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          if (bus.flush)      state <= ST_IDLE;
          else if (calc_done) state <= ST_FIN;
        end
        ST_FIN: begin
          state <= ST_IDLE;
          // A squash in FIN drops the result entirely.
          if (!bus.flush) begin
            case (op_q)
              OP_MULT, OP_MULTU: {hi_r, lo_r} <= prod;
              OP_MADD, OP_MADDU: {hi_r, lo_r} <= hilo + prod;
              OP_MSUB, OP_MSUBU: {hi_r, lo_r} <= hilo - prod;
              OP_MUL:            mul_res <= prod[31:0];
              default: ;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rd_data = '0;
    case (bus.rd_sel)
      RD_HI:   bus.rd_data = hi_r;
      RD_LO:   bus.rd_data = lo_r;
      RD_MUL:  bus.rd_data = mul_res;
      default: bus.rd_data = '0;
    endcase
  end

  assign bus.ready = idle;
  assign bus.busy  = !idle;
  assign bus.stall = (bus.start || (bus.rd_sel != RD_NONE)) && !idle;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;

endmodule
